// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and reset values for serial_sub
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam state_e RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

endpackage

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - one-bit full subtractor: d = a - b - bin, bout = borrow out
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, LSB first, one bit per cycle
// Optional SERIAL_SUB_SAT_EN clamps an underflowing result to zero.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;

    fs_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The minuend register doubles as the result accumulator: each cycle the
    // consumed LSB falls off and the new difference bit enters at the MSB.
    always_comb begin
        res_next            = a_q >> 1;
        res_next[WIDTH-1]   = d_bit;

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = res_next;
                b_d   = b_q >> 1;
                br_d  = bout_bit;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    borrow_d = bout_bit;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = bout_bit ? '0 : res_next;
`else
                    diff_d   = res_next;
`endif
                    zero_d   = (diff_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= RST_BIT;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= RST_BIT;
            zero_q   <= RST_BIT;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed self-checking bench for serial_sub (WIDTH=8 and WIDTH=1)
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, borrow8, zero8;
    logic [7:0] diff8;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, borrow1, zero1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;

    longint exp_diff8;
    bit     exp_borrow8, exp_zero8;
    bit     sb_armed = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow(borrow8), .zero(zero8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1), .zero(zero1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: a - b - bin taken as a signed integer, then wrapped.
    function automatic void model(input int w, input longint a, input longint b,
                                  input longint bin, output longint d,
                                  output bit br, output bit z);
        longint full;
        longint mask;
        full = a - b - bin;
        mask = (longint'(1) << w) - 1;
        br   = (full < 0);
        d    = full & mask;
`ifdef SERIAL_SUB_SAT_EN
        if (br) d = 0;
`endif
        z = (d == 0);
    endfunction

    always @(negedge clk) begin
        if (sb_armed && out_valid8) begin
            check("sb_diff", longint'(diff8), exp_diff8);
            check("sb_borrow", longint'(borrow8), longint'(exp_borrow8));
            check("sb_zero", longint'(zero8), longint'(exp_zero8));
        end
    end

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                        input bit early_ready, input int hold);
        int cyc;
        model(8, longint'(av), longint'(bv), longint'(bv_in), exp_diff8, exp_borrow8, exp_zero8);
        sb_armed = 1'b1;
        @(negedge clk);
        check("in_ready_idle", longint'(in_ready8), 1);
        a8 = av; b8 = bv; bin8 = bv_in; in_valid8 = 1'b1;
        out_ready8 = early_ready;
        cyc = 0;
        @(negedge clk);
        in_valid8 = 1'b0;
        cyc = 1;
        check("in_ready_run", longint'(in_ready8), 0);
        while (!out_valid8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", longint'(cyc - 1), 8);
        if (early_ready) begin
            @(negedge clk);
            check("early_ready_ret", longint'(in_ready8), 1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
                in_valid8 = i[0];
                @(negedge clk);
                check("bp_out_valid", longint'(out_valid8), 1);
                check("bp_in_ready", longint'(in_ready8), 0);
            end
            in_valid8 = 1'b0;
            out_ready8 = 1'b1;
            @(negedge clk);
            check("handshake_in_ready", longint'(in_ready8), 1);
            check("handshake_out_valid", longint'(out_valid8), 0);
        end
        out_ready8 = 1'b0;
        sb_armed = 1'b0;
    endtask

    initial begin
        longint md;
        bit     mb, mz;

        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(in_ready8), 1);
        check("rst_out_valid", longint'(out_valid8), 0);
        check("rst_diff", longint'(diff8), 0);
        check("rst_borrow", longint'(borrow8), 0);
        check("rst_zero", longint'(zero8), 0);
        rst = 1'b0;

        model(8, 'h5A, 'h3C, 0, md, mb, mz);
        check("pin_5a_3c", md, 'h1E);
        check("pin_5a_3c_br", longint'(mb), 0);
        model(8, 'h00, 'h01, 0, md, mb, mz);
`ifdef SERIAL_SUB_SAT_EN
        check("pin_under", md, 'h00);
        check("pin_under_z", longint'(mz), 1);
`else
        check("pin_under", md, 'hFF);
`endif
        check("pin_under_br", longint'(mb), 1);
        model(1, 0, 1, 1, md, mb, mz);
        check("pin_w1", md, 0);
        check("pin_w1_br", longint'(mb), 1);

        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        check("lit_5a_3c_diff", longint'(diff8), 'h1E);
        run8(8'h00, 8'h01, 1'b0, 1'b0, 0);
        check("lit_under_borrow", longint'(borrow8), 1);
        run8(8'h10, 8'h10, 1'b1, 1'b0, 0);
        run8(8'h10, 8'h10, 1'b0, 1'b0, 0);
        check("lit_zero", longint'(zero8), 1);
        run8(8'hFF, 8'h00, 1'b1, 1'b1, 0);
        run8(8'h80, 8'h7F, 1'b0, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b0, 1'b0, 5);

        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", longint'(in_ready8), 1);
        check("midrst_out_valid", longint'(out_valid8), 0);
        check("midrst_diff", longint'(diff8), 0);
        check("midrst_borrow", longint'(borrow8), 0);
        repeat (10) @(negedge clk);
        check("midrst_no_result", longint'(out_valid8), 0);

        for (int v = 0; v < 8; v++) begin
            model(1, longint'(v[2]), longint'(v[1]), longint'(v[0]), md, mb, mz);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; in_valid1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            check("w1_not_yet", longint'(out_valid1), 0);
            @(negedge clk);
            check("w1_valid", longint'(out_valid1), 1);
            check("w1_diff", longint'(diff1), md);
            check("w1_borrow", longint'(borrow1), longint'(mb));
            check("w1_zero", longint'(zero1), longint'(mz));
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
            check("w1_idle", longint'(in_ready1), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result held on diff/borrow/zero.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port borrow  output  1  borrow-out of the MSB stage (1 when a < b + bin, unsigned).
REQ-013 SHALL have port zero  output  1  1 when diff == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 SHALL, in IDLE with in_valid = 1, capture a, b, bin into internal shift/borrow registers, clear bit counter, enter RUN.
REQ-016 SHALL, in RUN, process exactly one bit per cycle LSB first: d_i = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
REQ-017 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-018 SHALL hold diff, borrow, zero stable while in DONE until out_valid & out_ready, then return to IDLE on that edge.
REQ-019 SHALL NOT accept a new operand set in RUN or DONE; in_valid ignored there; minimum initiation interval WIDTH+2 cycles.
REQ-020 SHALL drive diff, borrow, zero from registers only (no combinational path from inputs to outputs).
REQ-021 SHALL handle WIDTH = 1: one RUN cycle, result equals a single-bit borrow cell.
REQ-022 SHALL treat out_ready asserted before out_valid as no effect.

Reset
REQ-023 SHALL, with rst = 1 at a rising edge, force state IDLE, diff = 0, borrow = 0, zero = 0, bit counter = 0, from any state including mid-RUN (in-flight operation discarded).
REQ-024 SHALL present in_ready = 1 in the first cycle after reset deasserts; rst has priority over in_valid and out_ready.

Configuration
REQ-025 SHALL, with macro SERIAL_SUB_SAT_EN defined, clamp diff to 0 (zero = 1) whenever final borrow = 1; borrow still reported as 1.
REQ-026 SHALL, without SERIAL_SUB_SAT_EN, output wrapped two's-complement diff; latency unchanged in both builds.

Structure
REQ-027 SHALL place the state enum typedef (IDLE/RUN/DONE) and the reset-value constants in package serial_sub_pkg.
REQ-028 SHALL instantiate one 1-bit combinational borrow cell sub-module fs_cell (a, b, bin -> d, bout) for the per-cycle stage.
REQ-029 SHALL size the bit counter as $clog2(WIDTH) bits, minimum 1.

Verification
REQ-030 SHALL cover WIDTH=8: a=0x5A, b=0x3C, bin=0 -> after 8 cycles out_valid=1, diff=0x1E, borrow=0, zero=0.
REQ-031 SHALL cover underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1; with SERIAL_SUB_SAT_EN diff=0x00, zero=1, borrow=1.
REQ-032 SHALL cover borrow-in and zero: a=0x10, b=0x10, bin=1 -> diff=0xFF, borrow=1; a=0x10, b=0x10, bin=0 -> diff=0x00, zero=1, borrow=0.
REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 SHALL cover reset mid-RUN after 3 bits processed -> next cycle state IDLE, diff=0, borrow=0, out_valid=0, in_ready=1.
REQ-035 SHALL cover WIDTH=1: a=0, b=1, bin=1 -> after 1 cycle diff=0, borrow=1.
